// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline register and ALU operand delivery for the RV32IM pipeline.
// It captures the decoded instruction from ID and presents the ALU operands
// with result forwarding from the MEM and WB stages. It also detects load-use
// hazards (stall plus bubble) and kills the entering instruction on a flush.
//
// Ports:
//   CLK, RESET            clock (rising edge), synchronous active-high reset
//   ID_*                  decoded instruction fields and control from ID
//   EXM_*                 destination/result of the instruction now in MEM
//   MWB_*                 destination/result of the instruction now in WB
//   FLUSH                 taken branch/jump: the instruction entering EX dies
//   DATA1, DATA2          forwarded and muxed ALU operands (combinational)
//   ALU_OPCODE            registered ALU operation
//   EX_*                  registered control, rd, PC; EX_STORE_DATA = fwd rs2
//   STALL                 load-use hazard: hold PC and IF/ID this cycle
// -----------------------------------------------------------------------------
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            ID_VALID,
  input  logic [XLEN-1:0] ID_PC,
  input  logic [4:0]      ID_RS1_ADDR,
  input  logic [4:0]      ID_RS2_ADDR,
  input  logic [4:0]      ID_RD_ADDR,
  input  logic [XLEN-1:0] ID_RS1_DATA,
  input  logic [XLEN-1:0] ID_RS2_DATA,
  input  logic [XLEN-1:0] ID_IMM,
  input  logic [OPW-1:0]  ID_ALU_OPCODE,
  input  logic            ID_OP1_SEL,
  input  logic            ID_OP2_SEL,
  input  logic            ID_USES_RS1,
  input  logic            ID_USES_RS2,
  input  logic            ID_REG_WRITE,
  input  logic            ID_MEM_READ,
  input  logic            ID_MEM_WRITE,
  input  logic            EXM_REG_WRITE,
  input  logic [4:0]      EXM_RD_ADDR,
  input  logic [XLEN-1:0] EXM_RESULT,
  input  logic            MWB_REG_WRITE,
  input  logic [4:0]      MWB_RD_ADDR,
  input  logic [XLEN-1:0] MWB_RESULT,
  input  logic            FLUSH,
  output logic [XLEN-1:0] DATA1,
  output logic [XLEN-1:0] DATA2,
  output logic [OPW-1:0]  ALU_OPCODE,
  output logic            EX_VALID,
  output logic            EX_REG_WRITE,
  output logic            EX_MEM_READ,
  output logic            EX_MEM_WRITE,
  output logic [4:0]      EX_RD_ADDR,
  output logic [XLEN-1:0] EX_PC,
  output logic [XLEN-1:0] EX_STORE_DATA,
  output logic            STALL
);

  logic            vld_p0;
  logic [XLEN-1:0] pc_p0;
  logic [4:0]      rs1_addr_p0;
  logic [4:0]      rs2_addr_p0;
  logic [4:0]      rd_addr_p0;
  logic [XLEN-1:0] rs1_data_p0;
  logic [XLEN-1:0] rs2_data_p0;
  logic [XLEN-1:0] imm_p0;
  logic [OPW-1:0]  opcode_p0;
  logic            op1_sel_p0;
  logic            op2_sel_p0;
  logic            reg_write_p0;
  logic            mem_read_p0;
  logic            mem_write_p0;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            bubble;

  // The register file has no write-through, so a value being written back
  // this cycle must be taken from the WB bus at capture time.
  function automatic logic [XLEN-1:0] wb_bypass(input logic [4:0]      rs,
                                                input logic [XLEN-1:0] rf_data);
    if (MWB_REG_WRITE && (MWB_RD_ADDR != 5'd0) && (MWB_RD_ADDR == rs))
      return MWB_RESULT;
    return rf_data;
  endfunction

  // EX-time forwarding: the MEM result is younger than the WB result and wins.
  // x0 is hardwired zero and never forwarded.
  function automatic logic [XLEN-1:0] fwd_operand(input logic [4:0]      rs,
                                                  input logic [XLEN-1:0] held);
    if (rs == 5'd0)
      return held;
    if (EXM_REG_WRITE && (EXM_RD_ADDR == rs))
      return EXM_RESULT;
    if (MWB_REG_WRITE && (MWB_RD_ADDR == rs))
      return MWB_RESULT;
    return held;
  endfunction

  // A load in EX cannot supply its data to the instruction in ID; hold ID one
  // cycle and send a bubble so the data arrives later over the WB path.
  assign STALL = vld_p0 && mem_read_p0 && (rd_addr_p0 != 5'd0) && ID_VALID &&
                 ((ID_USES_RS1 && (ID_RS1_ADDR == rd_addr_p0)) ||
                  (ID_USES_RS2 && (ID_RS2_ADDR == rd_addr_p0))) && !FLUSH;

  assign bubble = FLUSH || STALL || !ID_VALID;

  // Stage p0: ID -> EX capture
  always_ff @(posedge CLK) begin
    if (RESET || bubble) begin
      vld_p0       <= 1'b0;
      pc_p0        <= '0;
      rs1_addr_p0  <= '0;
      rs2_addr_p0  <= '0;
      rd_addr_p0   <= '0;
      rs1_data_p0  <= '0;
      rs2_data_p0  <= '0;
      imm_p0       <= '0;
      opcode_p0    <= '0;
      op1_sel_p0   <= 1'b0;
      op2_sel_p0   <= 1'b0;
      reg_write_p0 <= 1'b0;
      mem_read_p0  <= 1'b0;
      mem_write_p0 <= 1'b0;
    end else begin
      vld_p0       <= 1'b1;
      pc_p0        <= ID_PC;
      rs1_addr_p0  <= ID_RS1_ADDR;
      rs2_addr_p0  <= ID_RS2_ADDR;
      rd_addr_p0   <= ID_RD_ADDR;
      rs1_data_p0  <= wb_bypass(ID_RS1_ADDR, ID_RS1_DATA);
      rs2_data_p0  <= wb_bypass(ID_RS2_ADDR, ID_RS2_DATA);
      imm_p0       <= ID_IMM;
      opcode_p0    <= ID_ALU_OPCODE;
      op1_sel_p0   <= ID_OP1_SEL;
      op2_sel_p0   <= ID_OP2_SEL;
      reg_write_p0 <= ID_REG_WRITE;
      mem_read_p0  <= ID_MEM_READ;
      mem_write_p0 <= ID_MEM_WRITE;
    end
  end

  // Stage p0 outputs: forwarding and operand muxing, combinational
  assign fwd_rs1 = fwd_operand(rs1_addr_p0, rs1_data_p0);
  assign fwd_rs2 = fwd_operand(rs2_addr_p0, rs2_data_p0);

  assign DATA1         = op1_sel_p0 ? pc_p0  : fwd_rs1;
  assign DATA2         = op2_sel_p0 ? imm_p0 : fwd_rs2;
  assign EX_STORE_DATA = fwd_rs2;

  assign ALU_OPCODE   = opcode_p0;
  assign EX_VALID     = vld_p0;
  assign EX_REG_WRITE = reg_write_p0;
  assign EX_MEM_READ  = mem_read_p0;
  assign EX_MEM_WRITE = mem_write_p0;
  assign EX_RD_ADDR   = rd_addr_p0;
  assign EX_PC        = pc_p0;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_operand_stage
//
// Self-checking bench for id_ex_operand_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
// -----------------------------------------------------------------------------
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_alu_opcode;
  logic        id_op1_sel, id_op2_sel, id_uses_rs1, id_uses_rs2;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        exm_reg_write;
  logic [4:0]  exm_rd_addr;
  logic [31:0] exm_result;
  logic        mwb_reg_write;
  logic [4:0]  mwb_rd_addr;
  logic [31:0] mwb_result;
  logic        flush;
  logic [31:0] data1, data2, ex_pc, ex_store_data;
  logic [4:0]  alu_opcode, ex_rd_addr;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.XLEN(32), .OPW(5)) dut (
    .CLK(clk), .RESET(reset), .ID_VALID(id_valid), .ID_PC(id_pc),
    .ID_RS1_ADDR(id_rs1_addr), .ID_RS2_ADDR(id_rs2_addr), .ID_RD_ADDR(id_rd_addr),
    .ID_RS1_DATA(id_rs1_data), .ID_RS2_DATA(id_rs2_data), .ID_IMM(id_imm),
    .ID_ALU_OPCODE(id_alu_opcode), .ID_OP1_SEL(id_op1_sel), .ID_OP2_SEL(id_op2_sel),
    .ID_USES_RS1(id_uses_rs1), .ID_USES_RS2(id_uses_rs2),
    .ID_REG_WRITE(id_reg_write), .ID_MEM_READ(id_mem_read), .ID_MEM_WRITE(id_mem_write),
    .EXM_REG_WRITE(exm_reg_write), .EXM_RD_ADDR(exm_rd_addr), .EXM_RESULT(exm_result),
    .MWB_REG_WRITE(mwb_reg_write), .MWB_RD_ADDR(mwb_rd_addr), .MWB_RESULT(mwb_result),
    .FLUSH(flush), .DATA1(data1), .DATA2(data2), .ALU_OPCODE(alu_opcode),
    .EX_VALID(ex_valid), .EX_REG_WRITE(ex_reg_write), .EX_MEM_READ(ex_mem_read),
    .EX_MEM_WRITE(ex_mem_write), .EX_RD_ADDR(ex_rd_addr), .EX_PC(ex_pc),
    .EX_STORE_DATA(ex_store_data), .STALL(stall)
  );

  // Behavioural picture of the instruction currently sitting in EX.
  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] v1, v2, imm;
    logic [4:0]  op;
    logic        use_pc, use_imm, rw, mr, mw;
  } ex_t;

  ex_t m;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Value of register r as seen by the instruction in EX right now.
  function automatic logic [31:0] seen_value(input logic [4:0] r, input logic [31:0] held);
    logic [31:0] v;
    v = held;
    if (r != 0) begin
      if (mwb_reg_write && mwb_rd_addr == r) v = mwb_result;
      if (exm_reg_write && exm_rd_addr == r) v = exm_result; // younger result wins
    end
    return v;
  endfunction

  function automatic logic expect_stall();
    logic dep;
    dep = (id_uses_rs1 && id_rs1_addr == m.rd) || (id_uses_rs2 && id_rs2_addr == m.rd);
    return m.vld && m.mr && (m.rd != 0) && id_valid && dep && !flush;
  endfunction

  // Check every output against the model, then advance one clock.
  task automatic step();
    logic [31:0] s1, s2;
    ex_t nx;
    #1;
    s1 = seen_value(m.rs1, m.v1);
    s2 = seen_value(m.rs2, m.v2);
    check_val("data1",      data1,              m.use_pc  ? m.pc  : s1);
    check_val("data2",      data2,              m.use_imm ? m.imm : s2);
    check_val("store_data", ex_store_data,      s2);
    check_val("opcode",     32'(alu_opcode),    32'(m.op));
    check_val("ex_valid",   32'(ex_valid),      32'(m.vld));
    check_val("reg_write",  32'(ex_reg_write),  32'(m.rw));
    check_val("mem_read",   32'(ex_mem_read),   32'(m.mr));
    check_val("mem_write",  32'(ex_mem_write),  32'(m.mw));
    check_val("rd_addr",    32'(ex_rd_addr),    32'(m.rd));
    check_val("ex_pc",      ex_pc,              m.pc);
    check_val("stall",      32'(stall),         32'(expect_stall()));
    nx = '0;
    if (!reset && !flush && !expect_stall() && id_valid) begin
      nx.vld = 1'b1; nx.pc = id_pc; nx.rs1 = id_rs1_addr; nx.rs2 = id_rs2_addr;
      nx.rd = id_rd_addr; nx.imm = id_imm; nx.op = id_alu_opcode;
      nx.use_pc = id_op1_sel; nx.use_imm = id_op2_sel;
      nx.rw = id_reg_write; nx.mr = id_mem_read; nx.mw = id_mem_write;
      nx.v1 = (mwb_reg_write && mwb_rd_addr != 0 && mwb_rd_addr == id_rs1_addr) ? mwb_result : id_rs1_data;
      nx.v2 = (mwb_reg_write && mwb_rd_addr != 0 && mwb_rd_addr == id_rs2_addr) ? mwb_result : id_rs2_data;
    end
    @(posedge clk);
    #1;
    m = nx;
  endtask

  task automatic clear_inputs();
    reset = 0; id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_opcode = 0;
    id_op1_sel = 0; id_op2_sel = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    exm_reg_write = 0; exm_rd_addr = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd_addr = 0; mwb_result = 0; flush = 0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [4:0] rd, input logic ld);
    id_valid = 1; id_pc = 32'h100 + 32'(rd) * 4; id_rs1_addr = rs1; id_rs1_data = d1;
    id_rs2_addr = rs2; id_rs2_data = d2; id_rd_addr = rd; id_imm = 32'h40;
    id_alu_opcode = ld ? 5'd0 : 5'd1; id_op1_sel = 0; id_op2_sel = ld;
    id_uses_rs1 = 1; id_uses_rs2 = !ld; id_reg_write = 1; id_mem_read = ld; id_mem_write = 0;
  endtask

  initial begin
    m = '0;
    clear_inputs();

    // Reset with a valid instruction waiting in ID
    reset = 1;
    set_id(5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 1'b0);
    step(); step();
    check_val("rst_ex_valid", 32'(ex_valid), 32'd0);
    check_val("rst_data1", data1, 32'd0);
    check_val("rst_data2", data2, 32'd0);
    check_val("rst_opcode", 32'(alu_opcode), 32'd0);
    check_val("rst_stall", 32'(stall), 32'd0);
    reset = 0;

    // Basic capture: ADD x3, x1(5), x2(7)
    set_id(5'd1, 32'h5, 5'd2, 32'h7, 5'd3, 1'b0);
    step();
    check_val("cap_data1", data1, 32'h5);
    check_val("cap_data2", data2, 32'h7);
    check_val("cap_rd", 32'(ex_rd_addr), 32'd3);
    check_val("cap_valid", 32'(ex_valid), 32'd1);

    // Forward priority on rs1 = x4
    set_id(5'd4, 32'h11, 5'd9, 32'h33, 5'd7, 1'b0);
    step();
    exm_reg_write = 1; exm_rd_addr = 5'd4; exm_result = 32'hAAAA0000;
    mwb_reg_write = 1; mwb_rd_addr = 5'd4; mwb_result = 32'h1234;
    #1 check_val("fwd_exm_first", data1, 32'hAAAA0000);
    exm_reg_write = 0;
    #1 check_val("fwd_mwb", data1, 32'h1234);
    exm_reg_write = 1; exm_rd_addr = 5'd0; mwb_rd_addr = 5'd0;
    set_id(5'd0, 32'h55, 5'd9, 32'h33, 5'd7, 1'b0);
    step();
    check_val("fwd_x0_raw", data1, 32'h55);
    exm_reg_write = 0; mwb_reg_write = 0;

    // Load-use: LW x5 then ADD x8, x2, x5
    set_id(5'd1, 32'h1000, 5'd0, 32'h0, 5'd5, 1'b1);
    step();
    set_id(5'd2, 32'h3, 5'd5, 32'h0, 5'd8, 1'b0);
    #1 check_val("lu_stall", 32'(stall), 32'd1);
    step();
    exm_reg_write = 1; exm_rd_addr = 5'd5; exm_result = 32'h1040;
    check_val("lu_bubble", 32'(ex_valid), 32'd0);
    check_val("lu_stall_drop", 32'(stall), 32'd0);
    step();
    exm_reg_write = 0;
    mwb_reg_write = 1; mwb_rd_addr = 5'd5; mwb_result = 32'hDEAD;
    #1 check_val("lu_data2", data2, 32'hDEAD);
    check_val("lu_valid", 32'(ex_valid), 32'd1);
    step();
    mwb_reg_write = 0;

    // Flush overrides stall
    set_id(5'd1, 32'h1000, 5'd0, 32'h0, 5'd5, 1'b1);
    step();
    set_id(5'd2, 32'h3, 5'd5, 32'h0, 5'd8, 1'b0);
    flush = 1;
    #1 check_val("fl_stall", 32'(stall), 32'd0);
    step();
    flush = 0;
    check_val("fl_valid", 32'(ex_valid), 32'd0);

    // Reset while a load-use stall is pending
    set_id(5'd1, 32'h1000, 5'd0, 32'h0, 5'd5, 1'b1);
    step();
    set_id(5'd5, 32'h0, 5'd2, 32'h0, 5'd8, 1'b0);
    reset = 1;
    step();
    reset = 0;
    check_val("rs_mid_valid", 32'(ex_valid), 32'd0);
    check_val("rs_mid_stall", 32'(stall), 32'd0);

    // Capture-time WB bypass of x6
    set_id(5'd6, 32'h0, 5'd0, 32'h0, 5'd9, 1'b0);
    mwb_reg_write = 1; mwb_rd_addr = 5'd6; mwb_result = 32'h99;
    step();
    mwb_reg_write = 0;
    #1 check_val("bypass_data1", data1, 32'h99);

    // Randomized traffic, small register range to provoke matches
    for (int i = 0; i < 500; i++) begin
      reset         = ($urandom_range(0, 40) == 0);
      flush         = ($urandom_range(0, 10) == 0);
      id_valid      = ($urandom_range(0, 5) != 0);
      id_pc         = $urandom;
      id_rs1_addr   = 5'($urandom_range(0, 7));
      id_rs2_addr   = 5'($urandom_range(0, 7));
      id_rd_addr    = 5'($urandom_range(0, 7));
      id_rs1_data   = $urandom;
      id_rs2_data   = $urandom;
      id_imm        = $urandom;
      id_alu_opcode = 5'($urandom);
      id_op1_sel    = 1'($urandom);
      id_op2_sel    = 1'($urandom);
      id_uses_rs1   = 1'($urandom);
      id_uses_rs2   = 1'($urandom);
      id_reg_write  = 1'($urandom);
      id_mem_read   = ($urandom_range(0, 2) == 0);
      id_mem_write  = 1'($urandom);
      exm_reg_write = 1'($urandom);
      exm_rd_addr   = 5'($urandom_range(0, 7));
      exm_result    = $urandom;
      mwb_reg_write = 1'($urandom);
      mwb_rd_addr   = 5'($urandom_range(0, 7));
      mwb_result    = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and operand-delivery stage for the RV32IM pipeline. It captures decoded instructions from the ID stage and drives `DATA1`, `DATA2` and `ALU_OPCODE` into the ALU, with result forwarding from the MEM and WB stages. It also performs load-use hazard detection (stall plus bubble) and branch flush.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `OPW`, 5, ALU opcode width (matches `ALU_OPCODE`)

Ports:
- `CLK` in 1: clock, rising edge
- `RESET` in 1: reset, synchronous, active-high
- `ID_VALID` in 1: ID holds a real instruction
- `ID_PC` in XLEN: instruction PC
- `ID_RS1_ADDR`, `ID_RS2_ADDR`, `ID_RD_ADDR` in 5: register specifiers
- `ID_RS1_DATA`, `ID_RS2_DATA` in XLEN: register file read data
- `ID_IMM` in XLEN: sign-extended immediate
- `ID_ALU_OPCODE` in OPW: ALU operation (`definitions.v` encodings)
- `ID_OP1_SEL` in 1: 0 = rs1, 1 = PC
- `ID_OP2_SEL` in 1: 0 = rs2, 1 = immediate
- `ID_USES_RS1`, `ID_USES_RS2` in 1: instruction reads the operand register
- `ID_REG_WRITE`, `ID_MEM_READ`, `ID_MEM_WRITE` in 1: control bits
- `EXM_REG_WRITE` in 1, `EXM_RD_ADDR` in 5, `EXM_RESULT` in XLEN: instruction currently in MEM
- `MWB_REG_WRITE` in 1, `MWB_RD_ADDR` in 5, `MWB_RESULT` in XLEN: instruction currently in WB
- `FLUSH` in 1: taken branch/jump; kill the instruction entering EX
- `DATA1`, `DATA2` out XLEN: ALU operands
- `ALU_OPCODE` out OPW: registered opcode
- `EX_VALID`, `EX_REG_WRITE`, `EX_MEM_READ`, `EX_MEM_WRITE` out 1: registered control
- `EX_RD_ADDR` out 5; `EX_PC` out XLEN; `EX_STORE_DATA` out XLEN: forwarded rs2 value
- `STALL` out 1: hold PC and IF/ID this cycle

## Operation
- **Registered fields:** valid, PC, rs1/rs2/rd addresses, rs1/rs2 data, immediate, opcode, selects, control bits.
- **Capture rule each rising edge, in priority order:**
  - `RESET` → all fields 0.
  - `FLUSH` → bubble.
  - `STALL` → bubble.
  - `ID_VALID` = 0 → bubble.
  - Otherwise, load the ID fields.
- **Bubble:** all fields 0. EX_VALID, REG_WRITE, MEM_* = 0; rd, rs addresses = 0; opcode = 0.
- **Capture-time WB bypass:** if `MWB_REG_WRITE` and `MWB_RD_ADDR` ≠ 0 and equals `ID_RSx_ADDR`, capture `MWB_RESULT` instead of `ID_RSx_DATA`. This covers the register file having no write-through.
- **EX-time forwarding (combinational on registered rsx address), per operand x:**
  - `EXM_REG_WRITE` and `EXM_RD_ADDR` == rsx and rsx ≠ 0 → `EXM_RESULT`.
  - Else `MWB_REG_WRITE` and `MWB_RD_ADDR` == rsx and rsx ≠ 0 → `MWB_RESULT`.
  - Else the registered data.
  - EXM has priority over MWB. Register x0 is never forwarded.
- **Operand muxing:**
  - `DATA1` = OP1_SEL ? PC : fwd_rs1.
  - `DATA2` = OP2_SEL ? IMM : fwd_rs2.
  - `EX_STORE_DATA` = fwd_rs2 always.
- **Load-use hazard (combinational):** `STALL` = `EX_VALID` & `EX_MEM_READ` & (`EX_RD_ADDR` ≠ 0) & `ID_VALID` & ((`ID_USES_RS1` & `ID_RS1_ADDR` == `EX_RD_ADDR`) | (`ID_USES_RS2` & `ID_RS2_ADDR` == `EX_RD_ADDR`)) & ~`FLUSH`.
- **Consequences of the load-use rule:**
  - A stall inserts exactly one bubble. The next cycle the load sits in MEM, and its data then arrives via the WB path one cycle later.
  - The rule ensures `EXM_RESULT` is never a load address consumed as data.
- **Flush:** `FLUSH` overrides `STALL`; STALL is forced to 0 while FLUSH = 1.

## Timing
- One-cycle latency: ID fields at edge N appear on the EX outputs after edge N.
- `DATA1`, `DATA2`, `EX_STORE_DATA` and `STALL` are combinational from registers and same-cycle EXM/MWB/ID inputs. There is no added cycle.
- **Reset values:** every registered output is 0. `DATA1` = `DATA2` = 0 (rs addresses are 0, so nothing is forwarded). `STALL` = 0.
- **Reset mid-stall:** the next cycle is a bubble; STALL deasserts, since `EX_MEM_READ` = 0.
- **Back-to-back loads to the same rd:** each dependent consumer gets one bubble. There is no cumulative stall.
- **Simultaneous EXM and MWB match on the same register:** EXM is selected (younger result).

## Test plan
1. **Reset and bubble:** hold `RESET` 2 cycles with valid ID input → `EX_VALID` = 0, `DATA1` = `DATA2` = 0, `ALU_OPCODE` = 0, `STALL` = 0.
2. **Basic capture:** ADD x3, rs1 = x1 (0x5), rs2 = x2 (0x7), no forwarding → next cycle `DATA1` = 0x5, `DATA2` = 0x7, `EX_RD_ADDR` = 3, `EX_VALID` = 1.
3. **Forward priority:**
   - Setup: EX holds rs1 = x4. `EXM_RD_ADDR` = 4 with `EXM_RESULT` = 0xAAAA0000; `MWB_RD_ADDR` = 4 with `MWB_RESULT` = 0x1234; both write-enabled.
   - Expected: `DATA1` = 0xAAAA0000.
   - Then drop `EXM_REG_WRITE` → `DATA1` = 0x1234.
   - Then make the register x0 → raw data.
4. **Load-use:** LW x5 in EX, ID = ADD rs2 = x5 → `STALL` = 1 for one cycle. The next EX is a bubble (`EX_VALID` = 0). The following cycle the ADD enters with `DATA2` = `MWB_RESULT` (e.g. 0xDEAD).
5. **Flush vs stall:** create the load-use condition of test 4 with `FLUSH` = 1 → `STALL` = 0, next `EX_VALID` = 0.
6. **Capture-time bypass:** ID reads x6 (stale 0x0) while `MWB` writes x6 = 0x99 → after the edge, the registered rs1 = 0x99, and `DATA1` = 0x99 once the MWB inputs clear.
